axi_lite_w_join: RTL and testbench

- Upstream feeder for the write clock-domain crossing, entirely in clka domain.
- Accepts an AXI4-Lite slave write (AW, W, B channels) from the bus master and joins AW and W into a single address+data write beat on a valid/ready master port.
- The master port drives the crossing's clka-side write inputs.
- Returns the B response only after the crossing has accepted the beat. At most one write is outstanding.

---
 rtl/axi_lite_w_join.sv | 136 +++++++++++++
 tb/tb_axi_lite_w_join.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_w_join.sv
// axi_lite_w_join
//   Feeds the write clock-domain crossing. The block runs entirely in the clka domain.
//   It accepts an AXI4-Lite slave write on the AW, W and B channels. It joins the
//   address and the data into one beat and presents that beat on a valid/ready
//   master port. The B response is returned only after the crossing has taken the
//   beat, so at most one write is outstanding.
//
//   Optional feature: define AXI_W_STRB_EN to enable the strobe check. When it is
//   enabled, a W beat whose strobes are not all ones (this includes all zeros) is
//   never forwarded. The write is answered with SLVERR instead. In the default
//   build the strobes are ignored and every write is forwarded as a full word.
//
// Parameters
//   aw : word address width on the master port. The slave byte address is aw+2 bits.
//   w  : data width. It must be a multiple of 8.
//
// Ports
//   clka, rst_n                   clock and asynchronous active-low reset
//   s_aw{valid,ready,addr}        AXI4-Lite write address channel (slave side)
//   s_w{valid,ready,data,strb}    AXI4-Lite write data channel (slave side)
//   s_b{valid,ready,resp}         AXI4-Lite write response channel (slave side)
//   m_w{valid,ready,addr,data}    joined address+data beat to the crossing

module axi_lite_w_join #(
    parameter int aw = 4,
    parameter int w  = 32
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [aw+1:0]     s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [w-1:0]      s_wdata,
    input  logic [w/8-1:0]    s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [aw-1:0]     m_waddr,
    output logic [w-1:0]      m_wdata
);

    // The state is derived from the three flags, not stored separately.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        RESP    = 2'd2
    } state_t;

    logic   aw_full;
    logic   w_full;
    logic   b_pend;
    logic   w_err;
    state_t state;

    logic   aw_hs;
    logic   w_hs;
    logic   b_hs;
    logic   issue_hs;
    logic   err_take;

    // The byte-offset bits are unused by design. The strobes are also unused when
    // the strobe check is compiled out.
    logic   unused_bits;
    assign unused_bits = ^{s_awaddr[1:0], s_wstrb};

    always_comb begin
        state = COLLECT;
        if (b_pend) begin
            state = RESP;
        end else if (aw_full && w_full) begin
            state = ISSUE;
        end
    end

    // The ready signals depend only on the hold flags. A hold that empties on an
    // edge therefore cannot reload on that same edge.
    assign s_awready = !aw_full;
    assign s_wready  = !w_full;
    assign s_bvalid  = b_pend;
    assign m_wvalid  = (state == ISSUE) && !w_err;

    assign aw_hs    = s_awvalid && s_awready;
    assign w_hs     = s_wvalid && s_wready;
    assign b_hs     = s_bvalid && s_bready;
    assign issue_hs = m_wvalid && m_wready;
    // A flagged pair is retired locally one cycle after both holds fill.
    // It is never shown to the crossing.
    assign err_take = (state == ISSUE) && w_err;

`ifdef AXI_W_STRB_EN
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            w_err <= 1'b0;
        end else if (w_hs) begin
            w_err <= (s_wstrb != {(w/8){1'b1}});
        end
    end
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            b_pend  <= 1'b0;
            s_bresp <= 2'b00;
            m_waddr <= '0;
            m_wdata <= '0;
        end else begin
            if (issue_hs || err_take) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                b_pend  <= 1'b1;
                s_bresp <= err_take ? 2'b10 : 2'b00;
            end else if (b_hs) begin
                b_pend  <= 1'b0;
            end
            // Acceptance only happens into an empty hold. It can never coincide
            // with the release above.
            if (aw_hs) begin
                aw_full <= 1'b1;
                m_waddr <= s_awaddr[aw+1:2];
            end
            if (w_hs) begin
                w_full  <= 1'b1;
                m_wdata <= s_wdata;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_w_join.sv
module tb_axi_lite_w_join;

    localparam int AW = 4;
    localparam int W  = 32;

    logic            clka = 1'b0;
    logic            rst_n;
    logic            s_awvalid;
    logic            s_awready;
    logic [AW+1:0]   s_awaddr;
    logic            s_wvalid;
    logic            s_wready;
    logic [W-1:0]    s_wdata;
    logic [W/8-1:0]  s_wstrb;
    logic            s_bvalid;
    logic            s_bready;
    logic [1:0]      s_bresp;
    logic            m_wvalid;
    logic            m_wready;
    logic [AW-1:0]   m_waddr;
    logic [W-1:0]    m_wdata;

    always #5 clka = ~clka;

    axi_lite_w_join #(.aw(AW), .w(W)) dut (
        .clka      (clka),
        .rst_n     (rst_n),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_bresp   (s_bresp),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_waddr   (m_waddr),
        .m_wdata   (m_wdata)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: writes accepted but not yet forwarded. The AW and W queues
    // are kept separately. A write is outstanding while bpend is set.
    logic [AW-1:0] aw_q[$];
    logic [W-1:0]  wd_q[$];
    bit            we_q[$];
    bit            bpend;
    logic [1:0]    exp_bresp;

    function automatic bit strb_bad(input logic [W/8-1:0] s);
`ifdef AXI_W_STRB_EN
        return s != {(W/8){1'b1}};
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        aw_q.delete();
        wd_q.delete();
        we_q.delete();
        bpend     = 1'b0;
        exp_bresp = 2'b00;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        bit pair;
        bit exp_mv;
        pair   = (aw_q.size() > 0) && (wd_q.size() > 0) && !bpend;
        exp_mv = 1'b0;
        if (pair) exp_mv = !we_q[0];
        chk("awready", 64'(s_awready), 64'(aw_q.size() == 0));
        chk("wready",  64'(s_wready),  64'(wd_q.size() == 0));
        chk("m_wvalid", 64'(m_wvalid), 64'(exp_mv));
        chk("s_bvalid", 64'(s_bvalid), 64'(bpend));
        if (exp_mv) begin
            chk("m_waddr", 64'(m_waddr), 64'(aw_q[0]));
            chk("m_wdata", 64'(m_wdata), 64'(wd_q[0]));
        end
        if (bpend) chk("s_bresp", 64'(s_bresp), 64'(exp_bresp));
    endtask

    // One clock: check the outputs against the model, advance the model across the
    // edge, then drop any valid that was accepted.
    task automatic step();
        bit aw_hs, w_hs, b_hs, fire, ferr;
        check_model();
        aw_hs = s_awvalid && (aw_q.size() == 0);
        w_hs  = s_wvalid && (wd_q.size() == 0);
        b_hs  = bpend && s_bready;
        fire  = 1'b0;
        ferr  = 1'b0;
        if ((aw_q.size() > 0) && (wd_q.size() > 0) && !bpend) begin
            ferr = we_q[0];
            fire = we_q[0] || m_wready;
        end
        @(posedge clka);
        if (fire) begin
            exp_bresp = ferr ? 2'b10 : 2'b00;
            void'(aw_q.pop_front());
            void'(wd_q.pop_front());
            void'(we_q.pop_front());
            bpend = 1'b1;
        end else if (b_hs) begin
            bpend = 1'b0;
        end
        if (aw_hs) aw_q.push_back(s_awaddr[AW+1:2]);
        if (w_hs) begin
            wd_q.push_back(s_wdata);
            we_q.push_back(strb_bad(s_wstrb));
        end
        #1;
        if (aw_hs) s_awvalid = 1'b0;
        if (w_hs)  s_wvalid  = 1'b0;
    endtask

    task automatic put_aw(input logic [AW+1:0] a);
        s_awvalid = 1'b1;
        s_awaddr  = a;
    endtask

    task automatic put_w(input logic [W-1:0] d, input logic [W/8-1:0] s);
        s_wvalid = 1'b1;
        s_wdata  = d;
        s_wstrb  = s;
    endtask

    initial begin
        rst_n     = 1'b0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '1;
        s_bready  = 1'b1;
        m_wready  = 1'b1;
        model_reset();
        repeat (3) @(posedge clka);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_awready", 64'(s_awready), 64'd1);
        chk("rst_wready",  64'(s_wready),  64'd1);
        chk("rst_m_wvalid", 64'(m_wvalid), 64'd0);
        chk("rst_s_bvalid", 64'(s_bvalid), 64'd0);
        chk("rst_m_waddr", 64'(m_waddr),   64'd0);

        // AW and W arrive together
        put_aw(6'h0C);
        put_w(32'hDEADBEEF, '1);
        step();
        chk("same_mv",   64'(m_wvalid), 64'd1);
        chk("same_addr", 64'(m_waddr),  64'd3);
        chk("same_data", 64'(m_wdata),  64'hDEADBEEF);
        step();
        chk("same_bvalid", 64'(s_bvalid), 64'd1);
        chk("same_bresp",  64'(s_bresp),  64'd0);
        chk("same_mv_off", 64'(m_wvalid), 64'd0);
        step();
        chk("same_bdone", 64'(s_bvalid), 64'd0);

        // W first, AW five cycles later
        put_w(32'h11, '1);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("wfirst_wready", 64'(s_wready), 64'd0);
            chk("wfirst_mv",     64'(m_wvalid), 64'd0);
            step();
        end
        put_aw(6'h04);
        step();
        chk("wfirst_mv_on", 64'(m_wvalid), 64'd1);
        chk("wfirst_addr",  64'(m_waddr),  64'd1);
        chk("wfirst_data",  64'(m_wdata),  64'h11);
        step();
        step();

        // The crossing stalls for ten cycles
        m_wready = 1'b0;
        put_aw(6'h20);
        put_w(32'hA5A5A5A5, '1);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("stall_mv",     64'(m_wvalid), 64'd1);
            chk("stall_addr",   64'(m_waddr),  64'd8);
            chk("stall_data",   64'(m_wdata),  64'hA5A5A5A5);
            chk("stall_bvalid", 64'(s_bvalid), 64'd0);
            step();
        end
        m_wready = 1'b1;
        step();
        chk("stall_bvalid_on", 64'(s_bvalid), 64'd1);
        step();

        // B is held off while a second pair is accepted
        s_bready = 1'b0;
        put_aw(6'h08);
        put_w(32'h1111, '1);
        step();
        step();
        put_aw(6'h30);
        put_w(32'h2222, '1);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("bhold_mv",     64'(m_wvalid), 64'd0);
            chk("bhold_bvalid", 64'(s_bvalid), 64'd1);
            step();
        end
        s_bready = 1'b1;
        step();
        chk("bhold_mv_on", 64'(m_wvalid), 64'd1);
        chk("bhold_addr",  64'(m_waddr),  64'hC);
        chk("bhold_data",  64'(m_wdata),  64'h2222);
        step();
        step();

        // Partial strobes
        put_aw(6'h14);
        put_w(32'h5555, 4'b0011);
        step();
`ifdef AXI_W_STRB_EN
        chk("strb_mv", 64'(m_wvalid), 64'd0);
        step();
        chk("strb_bvalid", 64'(s_bvalid), 64'd1);
        chk("strb_bresp",  64'(s_bresp),  64'd2);
`else
        chk("strb_mv", 64'(m_wvalid), 64'd1);
        step();
        chk("strb_bvalid", 64'(s_bvalid), 64'd1);
        chk("strb_bresp",  64'(s_bresp),  64'd0);
`endif
        step();
        s_wstrb = '1;

        // A reset in the middle of a transaction discards the held address
        put_aw(6'h3C);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_awready", 64'(s_awready), 64'd1);
        chk("midrst_addr",    64'(m_waddr),   64'd0);
        model_reset();
        @(negedge clka);
        rst_n = 1'b1;
        put_aw(6'h18);
        put_w(32'h77, '1);
        step();
        chk("midrst_new_addr", 64'(m_waddr), 64'd6);
        step();
        step();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            if (!s_awvalid && ($urandom_range(1, 0) != 0)) put_aw(6'($urandom));
            if (!s_wvalid && ($urandom_range(1, 0) != 0)) begin
                case ($urandom_range(7, 0))
                    0:       put_w($urandom, '0);
                    1:       put_w($urandom, 4'($urandom));
                    default: put_w($urandom, '1);
                endcase
            end
            m_wready = ($urandom_range(3, 0) != 0);
            s_bready = ($urandom_range(1, 0) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
